// File: rtl/redmule_pkg.sv
// Shared RedMulE types and constants.
// Holds the TCDM response bundle and responder constants.
package redmule_pkg;

    typedef struct packed {
        logic [31:0] r_data;
        logic        r_valid;
    } tcdm_resp_t;

    localparam logic [31:0] TCDM_OOR_DATA = 32'hDEAD_BEEF;

    // Fibonacci taps 16,14,13,11 as a bit mask
    localparam logic [15:0] TCDM_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/redmule_tcdm_bank.sv
// Single-port SRAM bank with byte enables.
// Read data is registered and held until the next read.
module redmule_tcdm_bank
    import redmule_pkg::*;
#(
    parameter int unsigned WORDS = 1024
) (
    input  logic                     clk_i,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [3:0]               be,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk_i) begin
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (en && !we) rdata <= mem[addr];
    end

endmodule

// File: rtl/redmule_tcdm_responder.sv
// Multi-port TCDM slave: interleaved banks, round-robin, 1-cycle latency.
// Define REDMULE_TCDM_STALL_EN for LFSR-driven random grant stalls.
module redmule_tcdm_responder
    import redmule_pkg::*;
#(
    parameter int unsigned MP         = 4,
    parameter int unsigned NB         = 8,
    parameter int unsigned BANK_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [MP-1:0]    tcdm_req,
    output logic [MP-1:0]    tcdm_gnt,
    input  logic [MP*32-1:0] tcdm_add,
    input  logic [MP-1:0]    tcdm_wen,
    input  logic [MP*4-1:0]  tcdm_be,
    input  logic [MP*32-1:0] tcdm_data,
    output logic [MP*32-1:0] tcdm_r_data,
    output logic [MP-1:0]    tcdm_r_valid,
    output logic             tcdm_r_opc,
    output logic             tcdm_r_user
);

    localparam int unsigned PW = $clog2(MP);
    localparam int unsigned BW = $clog2(NB);
    localparam int unsigned RW = $clog2(BANK_WORDS);
    localparam logic [31:0] N_WORDS = 32'(NB * BANK_WORDS);

    logic [31:0]   word [MP];
    logic [MP-1:0] oor;
    logic [BW-1:0] bank [MP];
    logic [RW-1:0] row  [MP];

    logic [MP-1:0] breq [NB];
    logic [PW:0]   pick [NB];
    logic [PW-1:0] rr_q [NB];
    logic [MP-1:0] gnt_pre;
    logic [MP-1:0] stall;
    logic [NB-1:0] bank_en;

    logic          b_we    [NB];
    logic [RW-1:0] b_row   [NB];
    logic [3:0]    b_be    [NB];
    logic [31:0]   b_wdata [NB];
    logic [31:0]   b_rdata [NB];

    logic [MP-1:0] rsp_vld_q;
    logic [MP-1:0] rsp_rd_q;
    logic [MP-1:0] rsp_oor_q;
    logic [BW-1:0] rsp_bank_q [MP];
    tcdm_resp_t    resp [MP];

    // MSB flags a winner; low bits are the first requester at or after ptr
    function automatic logic [PW:0] rr_pick(
        input logic [MP-1:0] reqs,
        input logic [PW-1:0] ptr
    );
        logic [PW:0] res;
        int unsigned idx;
        res = '0;
        for (int k = MP - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % MP;
            if (reqs[PW'(idx)]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            word[p] = (tcdm_add[p*32 +: 32] - BASE_ADDR) >> 2;
            oor[p]  = word[p] >= N_WORDS;
            bank[p] = word[p][BW-1:0];
            row[p]  = word[p][BW +: RW];
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            for (int p = 0; p < MP; p++) begin
                breq[b][p] = tcdm_req[p] & ~oor[p] & (bank[p] == BW'(b));
            end
            pick[b] = rr_pick(breq[b], rr_q[b]);
        end
    end

    always_comb begin
        gnt_pre = tcdm_req & oor;
        for (int b = 0; b < NB; b++) begin
            if (pick[b][PW]) gnt_pre[pick[b][PW-1:0]] = 1'b1;
        end
        tcdm_gnt = gnt_pre & ~stall & {MP{rst_ni}};
        for (int b = 0; b < NB; b++) begin
            bank_en[b] = pick[b][PW] & tcdm_gnt[pick[b][PW-1:0]];
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            b_we[b]    = ~tcdm_wen[pick[b][PW-1:0]];
            b_row[b]   = row[pick[b][PW-1:0]];
            b_be[b]    = tcdm_be[4*int'(pick[b][PW-1:0]) +: 4];
            b_wdata[b] = tcdm_data[32*int'(pick[b][PW-1:0]) +: 32];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NB; b++) rr_q[b] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (bank_en[b]) begin
                    rr_q[b] <= (pick[b][PW-1:0] == PW'(MP - 1)) ?
                               '0 : pick[b][PW-1:0] + 1'b1;
                end
            end
        end
    end

`ifdef REDMULE_TCDM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= STALL_SEED;
        else         lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & TCDM_LFSR_TAPS)};
    end

    for (genvar p = 0; p < MP; p++) begin : g_stall
        assign stall[p] = ~|{lfsr_q[(2*p+1)%16], lfsr_q[(2*p)%16]};
    end
`else
    logic [15:0] unused_seed;
    assign unused_seed = STALL_SEED;
    assign stall = '0;
`endif

    for (genvar b = 0; b < NB; b++) begin : g_bank
        redmule_tcdm_bank #(
            .WORDS (BANK_WORDS)
        ) i_bank (
            .clk_i (clk_i),
            .en    (bank_en[b]),
            .we    (b_we[b]),
            .addr  (b_row[b]),
            .be    (b_be[b]),
            .wdata (b_wdata[b]),
            .rdata (b_rdata[b])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_vld_q <= '0;
            rsp_rd_q  <= '0;
            rsp_oor_q <= '0;
            for (int p = 0; p < MP; p++) rsp_bank_q[p] <= '0;
        end else begin
            rsp_vld_q <= tcdm_gnt;
            rsp_rd_q  <= tcdm_wen;
            rsp_oor_q <= oor;
            for (int p = 0; p < MP; p++) rsp_bank_q[p] <= bank[p];
        end
    end

    always_comb begin
        tcdm_r_data  = '0;
        tcdm_r_valid = '0;
        for (int p = 0; p < MP; p++) begin
            resp[p].r_valid = rsp_vld_q[p];
            resp[p].r_data  = '0;
            if (rsp_vld_q[p] && rsp_rd_q[p]) begin
                resp[p].r_data = rsp_oor_q[p] ? TCDM_OOR_DATA
                                              : b_rdata[rsp_bank_q[p]];
            end
            tcdm_r_data[p*32 +: 32] = resp[p].r_data;
            tcdm_r_valid[p]         = resp[p].r_valid;
        end
    end

    assign tcdm_r_opc  = 1'b0;
    assign tcdm_r_user = 1'b0;

endmodule
